// File: rtl/reg_file_sp.sv
// MiniRISC register file: one write/X-read port, one Y-read port, a stack pointer
// register with bounded push/pop and sticky flags, and a post-reset clear sequence.
module reg_file_sp #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned SP_ADDR = 15,
  parameter int unsigned SP_TOP  = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_x,
  input  logic              write_en,
  input  logic [DATA_W-1:0] wr_data_x,
  output logic [DATA_W-1:0] rd_data_x,
  input  logic [ADDR_W-1:0] addr_y,
  output logic [DATA_W-1:0] rd_data_y,
  input  logic [1:0]        sp_op,
  input  logic              flag_clr,
  output logic [DATA_W-1:0] sp,
  output logic              sp_ovf,
  output logic              sp_unf,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SP_TOP_W  = DATA_W'(SP_TOP);
  localparam logic [ADDR_W-1:0] SP_IDX    = ADDR_W'(SP_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        OP_PUSH   = 2'b01;
  localparam logic [1:0]        OP_POP    = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic                sp_ovf_q, sp_ovf_d;
  logic                sp_unf_q, sp_unf_d;
  logic [DATA_W-1:0]   sp_cur;
  logic                sp_written;

  // State register; the array itself is only initialised by the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      sp_ovf_q  <= 1'b0;
      sp_unf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      sp_ovf_q  <= sp_ovf_d;
      sp_unf_q  <= sp_unf_d;
      regs_q    <= regs_d;
    end
  end

  assign sp_cur     = regs_q[SP_IDX];
  assign sp_written = write_en && (addr_x == SP_IDX);

  // Next-state: clear walk, then normal writes and SP push/pop.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    regs_d    = regs_q;
    sp_ovf_d  = sp_ovf_q;
    sp_unf_d  = sp_unf_q;

    unique case (state_q)
      CLEAR: begin
        regs_d[clr_cnt_q] = (clr_cnt_q == SP_IDX) ? SP_TOP_W : '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Clear first so a same-cycle flag event wins.
        if (flag_clr) begin
          sp_ovf_d = 1'b0;
          sp_unf_d = 1'b0;
        end
        if (write_en) begin
          regs_d[addr_x] = wr_data_x;
        end
        // A software write to SP overrides any stack operation that cycle.
        if (!sp_written) begin
          if (sp_op == OP_PUSH) begin
            if (sp_cur != '0) begin
              regs_d[SP_IDX] = sp_cur - DATA_W'(1);
            end else begin
              sp_ovf_d = 1'b1;
            end
          end else if (sp_op == OP_POP) begin
            if (sp_cur < SP_TOP_W) begin
              regs_d[SP_IDX] = sp_cur + DATA_W'(1);
            end else begin
              sp_unf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy      = (state_q == CLEAR);
  assign rd_data_x = busy ? '0 : regs_q[addr_x];
  assign rd_data_y = busy ? '0 : regs_q[addr_y];
  assign sp        = busy ? SP_TOP_W : sp_cur;
  assign sp_ovf    = sp_ovf_q;
  assign sp_unf    = sp_unf_q;

endmodule
